// File: rtl/mem_access_pkg.sv
// Shared funct3 encodings, FSM state type and request-classification helpers
// for the data-memory access unit.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StRmwRd = 3'd2,
    StWr    = 3'd3,
    StResp  = 3'd4
  } state_e;

  // Stores only have signed encodings; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Combinational lane logic: load extract/extend and byte/halfword store merge.
module mem_access_lane
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word[{off, 3'b000} +: 8];
    half_sel = off[1] ? old_word[31:16] : old_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = old_word;
    endcase

    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator; sub-word stores are done as read-modify-write
// because the memory only writes whole words.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, wbuf_q, rdata_q;
  logic [31:0] load_data, store_word;
  logic        req_bad;

  always_comb begin
    req_bad = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]) ||
              ({req_addr[31:2], 2'b00} >= MEM_BYTES);
  end

  mem_access_lane u_lane (
    .old_word   (mem_rdata),
    .off        (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: if (req_valid) begin
          err_q   <= req_bad;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
        end
        StRd:    rdata_q <= load_data;
        StRmwRd: wbuf_q  <= store_word;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) begin
        if (req_bad)                   state_d = StResp;
        else if (!req_we)              state_d = StRd;
        else if (req_funct3 == F3_W)   state_d = StWr;
        else                           state_d = StRmwRd;
      end
      StRd:    state_d = StResp;
      StRmwRd: state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The memory bus is driven purely from state so reset drops it immediately.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      StRd, StRmwRd: begin
        mem_ce   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
      end
      StWr: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = (f3_q == F3_W) ? wdata_q : wbuf_q;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int          ce_cnt = 0, we_cnt = 0, rv_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;

  int checks = 0, errors = 0;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat, r_ce, r_we;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_ce) ce_cnt <= ce_cnt + 1;
    if (resp_valid) rv_cnt <= rv_cnt + 1;
    if (mem_ce && mem_we) begin
      we_cnt              <= we_cnt + 1;
      last_waddr          <= mem_addr;
      last_wdata          <= mem_wdata;
      mem[mem_addr[9:2]]  <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response and record its results.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int ce0, we0;
    @(negedge clk);
    ce0 = ce_cnt;
    we0 = we_cnt;
    check_eq("ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    // Scramble request fields after accept; the unit must have captured them.
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    r_lat = 1;
    while (!resp_valid && r_lat < 8) begin
      @(posedge clk);
      #1;
      r_lat++;
    end
    check_eq("resp_seen", {31'h0, resp_valid}, 32'h1);
    r_rdata = resp_rdata;
    r_err   = resp_err;
    @(posedge clk);
    #1;
    check_eq("one_pulse", {31'h0, resp_valid}, 32'h0);
    r_ce = ce_cnt - ce0;
    r_we = we_cnt - we0;
  endtask

  task automatic expect_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp);
    run_req(1'b0, f3, addr, 32'h0);
    check_eq({tag, "_data"}, r_rdata, exp);
    check_eq({tag, "_err"}, {31'h0, r_err}, 32'h0);
    check_eq({tag, "_lat"}, r_lat, 2);
  endtask

  task automatic expect_err(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    run_req(we, f3, addr, 32'hFFFF_FFFF);
    check_eq({tag, "_err"}, {31'h0, r_err}, 32'h1);
    check_eq({tag, "_data"}, r_rdata, 32'h0);
    check_eq({tag, "_lat"}, r_lat, 1);
    check_eq({tag, "_ce"}, r_ce, 0);
  endtask

  task automatic expect_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_word,
                              input int exp_lat);
    run_req(1'b1, f3, addr, wdata);
    check_eq({tag, "_err"}, {31'h0, r_err}, 32'h0);
    check_eq({tag, "_data"}, r_rdata, 32'h0);
    check_eq({tag, "_lat"}, r_lat, exp_lat);
    check_eq({tag, "_we"}, r_we, 1);
    check_eq({tag, "_waddr"}, last_waddr, {addr[31:2], 2'b00});
    check_eq({tag, "_wdata"}, last_wdata, exp_word);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    #1;
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", {31'h0, resp_err}, 32'h0);
    check_eq("rst_ce_we", {30'h0, mem_ce, mem_we}, 32'h0);
    check_eq("rst_maddr", mem_addr, 32'h0);
    check_eq("rst_mwdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Preload through the unit with word stores.
    expect_store("sw10", F3_W, 32'h10, 32'h8899AABB, 32'h8899AABB, 2);
    expect_store("sw20", F3_W, 32'h20, 32'h11223344, 32'h11223344, 2);

    expect_load("lb11", F3_B, 32'h11, 32'hFFFFFFAA);
    expect_load("lbu11", F3_BU, 32'h11, 32'h000000AA);
    expect_load("lh12", F3_H, 32'h12, 32'hFFFF8899);
    expect_load("lhu12", F3_HU, 32'h12, 32'h00008899);
    expect_load("lw10", F3_W, 32'h10, 32'h8899AABB);
    expect_load("lb10", F3_B, 32'h10, 32'hFFFFFFBB);

    expect_store("sb22", F3_B, 32'h22, 32'hDEADBEEF, 32'h11EF3344, 3);
    expect_load("lw20", F3_W, 32'h20, 32'h11EF3344);
    expect_store("sh12", F3_H, 32'h12, 32'h00001234, 32'h1234AABB, 3);
    expect_store("sh10", F3_H, 32'h10, 32'hFFFF5678, 32'h1234_5678, 3);
    expect_load("lw10b", F3_W, 32'h10, 32'h12345678);

    expect_store("sw3fc", F3_W, 32'h3FC, 32'hCAFEF00D, 32'hCAFEF00D, 2);
    expect_load("lw3fc", F3_W, 32'h3FC, 32'hCAFEF00D);
    expect_load("lb3ff", F3_B, 32'h3FF, 32'hFFFFFFCA);
    expect_err("sw400", 1'b1, F3_W, 32'h400);
    expect_err("lb400", 1'b0, F3_B, 32'h400);

    expect_err("lw13", 1'b0, F3_W, 32'h13);
    expect_err("sh23", 1'b1, F3_H, 32'h23);
    expect_err("ld_f3_3", 1'b0, 3'b011, 32'h10);
    expect_err("st_f3_4", 1'b1, F3_BU, 32'h10);
    expect_err("lh11", 1'b0, F3_H, 32'h11);

    // Reset while the SB sits in RMW_RD: no write, no response.
    begin
      int we0, rv0;
      @(negedge clk);
      we0 = we_cnt;
      rv0 = rv_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_B;
      req_addr   = 32'h20;
      req_wdata  = 32'h000000AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("rmw_ce", {31'h0, mem_ce}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
      check_eq("abort_ce_we", {30'h0, mem_ce, mem_we}, 32'h0);
      check_eq("abort_maddr", mem_addr, 32'h0);
      check_eq("abort_valid", {31'h0, resp_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_no_we", we_cnt - we0, 0);
      check_eq("abort_no_resp", rv_cnt - rv0, 0);
    end
    expect_load("lw20_after", F3_W, 32'h20, 32'h11EF3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Pipeline-side initiator for the byte-addressed, word-wide data memory. It accepts one load/store request at a time from the MEM stage and drives the memory's `mem_ce`/`mem_we`/`mem_addr`/`mem_wdata` interface. Byte and halfword stores use read-modify-write, because the memory only writes whole words. It returns sign- or zero-extended load data and flags misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- MEM_BYTES, 1024: size of the memory in bytes. A word-aligned address ≥ MEM_BYTES is out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low bits used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected, no memory write performed.
- mem_ce  out  1  memory chip enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- **Reset values.** Reset is asynchronous and active-high. While rst=1: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_ce=0; mem_we=0; mem_addr=0; mem_wdata=0.
- **States.** IDLE, RD, RMW_RD, WR, RESP.
- **IDLE.**
  - req_ready=1.
  - On req_valid at a rising edge, the unit registers we, funct3, addr and wdata, then classifies the request:
    - err: halfword with addr[0]=1; word with addr[1:0]≠0; illegal funct3 (load 3/6/7, store ≥3); aligned word address ≥ MEM_BYTES.
    - Next state: err → RESP; load → RD; SW → WR; SB/SH → RMW_RD.
- **RD.**
  - mem_ce=1, mem_we=0, mem_addr=aligned address.
  - At the edge, select the lane at addr[1:0] from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into resp_rdata, then go to RESP.
- **RMW_RD.**
  - Same read as RD.
  - At the edge, wbuf = mem_rdata with the selected lane replaced by req_wdata[7:0] (SB, lane addr[1:0]) or req_wdata[15:0] (SH, lanes addr[1]*2..+1). Other bytes are unchanged.
  - Then go to WR.
- **WR.**
  - mem_ce=1, mem_we=1, mem_addr=aligned address.
  - mem_wdata = wbuf (SB/SH) or req_wdata (SW).
  - The memory commits at this edge; then go to RESP.
- **RESP.** resp_valid=1 for exactly one cycle with resp_err as classified; then go to IDLE. There is no response backpressure.
- **Memory idle.** mem_ce=0, mem_we=0 in IDLE and RESP; mem_addr and mem_wdata are held at 0 there.
- **Latency** (accept edge to resp_valid cycle):
  - error: 1 cycle;
  - load and SW: 2 cycles;
  - SB/SH: 3 cycles.
- **Throughput.** The next request can be accepted in the cycle after RESP.
- **Request stability.** req_* inputs are ignored outside IDLE; the requester may change them freely once accepted.
- **Reset mid-operation.** Asserting rst in RD/RMW_RD aborts the request with no write. Asserting rst in WR drops mem_we immediately; whether that write commits is defined by edge ordering and is not guaranteed. No resp_valid is issued for the aborted request.
- **Boundaries.**
  - Byte at MEM_BYTES-1 is legal.
  - Word at MEM_BYTES-4 is legal; word at MEM_BYTES is err.
  - SH at lane 2 (addr[1:0]=2) is legal.
  - SH at addr[1:0]=3 is err (misaligned).

Decomposition:
- **Package mem_access_pkg:**
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - 3-bit state encoding (IDLE=0, RD=1, RMW_RD=2, WR=3, RESP=4).
- **Sub-module mem_access_lane** (combinational):
  - load extract/extend from (word, addr[1:0], funct3);
  - store merge from (old word, new data, addr[1:0], funct3).
- **mem_access_unit** holds only the FSM and registers.

Test Plan:
1. Memory 0x10 = 0x8899AABB; LB addr 0x11 → resp_rdata = 0xFFFFFFAA, resp_err=0, resp_valid two cycles after accept. LBU addr 0x11 → 0x000000AA.
2. Memory 0x10 = 0x8899AABB; LH addr 0x12 → 0xFFFF8899. LHU addr 0x12 → 0x00008899. LW addr 0x10 → 0x8899AABB.
3. Memory 0x20 = 0x11223344; SB addr 0x22, wdata 0xDEADBEEF → exactly one mem_we pulse with mem_addr=0x20 and mem_wdata=0x11EF3344; resp_valid three cycles after accept; later LW 0x20 → 0x11EF3344.
4. SW addr 0x3FC, wdata 0xCAFEF00D → mem_we at 0x3FC, then LW 0x3FC → 0xCAFEF00D. SW addr 0x400 → resp_err=1, no mem_ce.
5. LW addr 0x13, SH addr 0x23, funct3=3'b011 load → each returns resp_err=1 one cycle after accept, mem_ce stays 0, resp_rdata=0.
6. Assert rst while in RMW_RD of SB 0x20 → all outputs go to reset values immediately, no mem_we, no resp_valid; memory 0x20 unchanged; next request is accepted normally.
